// File: rtl/counter_pkg.sv
// Shared types and sizing for the counter component's RAM-side scan engine.
package counter_pkg;

    localparam int unsigned COUNTER_DEPTH  = 512;
    localparam int unsigned COUNTER_ADDR_W = 9;
    localparam int unsigned COUNTER_DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FLUSH,
        S_DONE
    } scan_state_t;

endpackage

// File: rtl/run_tracker.sv
// Tracks the current and longest strictly increasing run over a stream of indexed words.
module run_tracker #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = ADDR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              init_i,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] index_i,
    input  logic [DATA_W-1:0] value_i,
    output logic [ADDR_W-1:0] best_pos_o,
    output logic [LEN_W-1:0]  best_len_o
);

    logic [ADDR_W-1:0] cur_pos_q, cur_pos_d;
    logic [LEN_W-1:0]  cur_len_q, cur_len_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [ADDR_W-1:0] best_pos_q, best_pos_d;
    logic [LEN_W-1:0]  best_len_q, best_len_d;

    always_comb begin
        cur_pos_d  = cur_pos_q;
        cur_len_d  = cur_len_q;
        prev_d     = prev_q;
        best_pos_d = best_pos_q;
        best_len_d = best_len_q;
        if (init_i) begin
            cur_pos_d  = '0;
            cur_len_d  = '0;
            prev_d     = '0;
            best_pos_d = '0;
            best_len_d = '0;
        end else if (valid_i) begin
            if (index_i == '0) begin
                cur_pos_d = '0;
                cur_len_d = LEN_W'(1);
            end else if (value_i > prev_q) begin
                cur_len_d = cur_len_q + LEN_W'(1);
            end else begin
                cur_pos_d = index_i;
                cur_len_d = LEN_W'(1);
            end
            prev_d = value_i;
            // Strict compare keeps the earliest run on ties.
            if (cur_len_d > best_len_q) begin
                best_pos_d = cur_pos_d;
                best_len_d = cur_len_d;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_pos_q  <= '0;
            cur_len_q  <= '0;
            prev_q     <= '0;
            best_pos_q <= '0;
            best_len_q <= '0;
        end else begin
            cur_pos_q  <= cur_pos_d;
            cur_len_q  <= cur_len_d;
            prev_q     <= prev_d;
            best_pos_q <= best_pos_d;
            best_len_q <= best_len_d;
        end
    end

    assign best_pos_o = best_pos_q;
    assign best_len_o = best_len_q;

endmodule

// File: rtl/longest_run_scanner.sv
// Read-only port-B scanner: walks the whole RAM on a start edge and reports the
// longest strictly increasing run (first index and length).
module longest_run_scanner
    import counter_pkg::*;
#(
    parameter int unsigned DEPTH      = COUNTER_DEPTH,
    parameter int unsigned ADDR_W     = COUNTER_ADDR_W,
    parameter int unsigned DATA_W     = COUNTER_DATA_W,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] read_data,
    output logic [ADDR_W-1:0] address,
    output logic              write_enable,
    output logic [15:0]       start_seq_pos,
    output logic [15:0]       length,
    output logic              finish,
    output logic              busy
);

    localparam int unsigned LEN_W   = ADDR_W + 1;
    localparam int unsigned FLUSH_W = $clog2(RD_LATENCY + 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    scan_state_t state_q, state_d;
    logic              start_q;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [15:0]       pos_q, pos_d;
    logic [15:0]       len_q, len_d;
    logic              finish_q, finish_d;
    logic              busy_q, busy_d;
    logic              trigger;
    logic              init;

    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [ADDR_W-1:0]     idx_q [RD_LATENCY];
    logic [ADDR_W-1:0]     idx_d [RD_LATENCY];

    logic [ADDR_W-1:0] best_pos;
    logic [LEN_W-1:0]  best_len;

    assign trigger = start & ~start_q & ((state_q == S_IDLE) || (state_q == S_DONE));

    // Tag each issued address so the tracker sees it alongside the returned word.
    always_comb begin
        vld_d[0] = (state_q == S_SCAN);
        idx_d[0] = address_q;
        for (int i = 1; i < int'(RD_LATENCY); i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        flush_cnt_d = flush_cnt_q;
        pos_d       = pos_q;
        len_d       = len_q;
        finish_d    = finish_q;
        busy_d      = busy_q;
        init        = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (trigger) begin
                    state_d   = S_SCAN;
                    address_d = '0;
                    busy_d    = 1'b1;
                    finish_d  = 1'b0;
                    init      = 1'b1;
                end
            end
            S_SCAN: begin
                if (address_q == LAST_ADDR) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = '0;
                end else begin
                    address_d = address_q + ADDR_W'(1);
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FLUSH_W'(RD_LATENCY)) begin
                    state_d  = S_DONE;
                    pos_d    = 16'(best_pos);
                    len_d    = 16'(best_len);
                    finish_d = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            address_q   <= '0;
            flush_cnt_q <= '0;
            pos_q       <= '0;
            len_q       <= '0;
            finish_q    <= 1'b0;
            busy_q      <= 1'b0;
            vld_q       <= '0;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            address_q   <= address_d;
            flush_cnt_q <= flush_cnt_d;
            pos_q       <= pos_d;
            len_q       <= len_d;
            finish_q    <= finish_d;
            busy_q      <= busy_d;
            vld_q       <= vld_d;
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                idx_q[i] <= idx_d[i];
            end
        end
    end

    run_tracker #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_run_tracker (
        .clk_i      (clock),
        .rst_i      (reset),
        .init_i     (init),
        .valid_i    (vld_q[RD_LATENCY-1]),
        .index_i    (idx_q[RD_LATENCY-1]),
        .value_i    (read_data),
        .best_pos_o (best_pos),
        .best_len_o (best_len)
    );

    assign address       = address_q;
    assign write_enable  = 1'b0;
    assign start_seq_pos = pos_q;
    assign length        = len_q;
    assign finish        = finish_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_longest_run_scanner.sv
// Bench for longest_run_scanner: RAM model with one-cycle read latency and an
// expected-result queue popped when each scan completes.
module tb_longest_run_scanner;

    localparam int unsigned DEPTH   = 512;
    localparam int unsigned LATENCY = 514;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] read_data;
    logic [8:0]  address;
    logic        write_enable;
    logic [15:0] start_seq_pos;
    logic [15:0] length;
    logic        finish;
    logic        busy;

    logic [15:0] mem [DEPTH];
    logic [31:0] exp_q [$];

    int tests_run    = 0;
    int tests_failed = 0;
    logic [15:0] last_pos;
    logic [15:0] last_len;

    longest_run_scanner #(
        .DEPTH      (DEPTH),
        .ADDR_W     (9),
        .DATA_W     (16),
        .RD_LATENCY (1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .read_data     (read_data),
        .address       (address),
        .write_enable  (write_enable),
        .start_seq_pos (start_seq_pos),
        .length        (length),
        .finish        (finish),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_ff @(posedge clock) read_data <= mem[address];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = v;
    endtask

    task automatic run_scan(input string tag, input logic [15:0] exp_pos, input logic [15:0] exp_len);
        int   lat;
        logic we_bad;
        logic [31:0] e;
        exp_q.push_back({exp_pos, exp_len});
        lat    = 0;
        we_bad = 1'b0;
        @(negedge clock) start = 1'b1;
        @(posedge clock);
        #1;
        check_eq({tag, "_busy_on"}, 32'(busy), 32'd1);
        check_eq({tag, "_finish_clr"}, 32'(finish), 32'd0);
        for (int n = 1; n <= 1000 && lat == 0; n++) begin
            @(posedge clock);
            #1;
            if (write_enable !== 1'b0) we_bad = 1'b1;
            if (n == 100) check_eq({tag, "_hold_len"}, 32'(length), 32'(last_len));
            if (finish === 1'b1) lat = n;
        end
        check_eq({tag, "_latency"}, lat, LATENCY);
        check_eq({tag, "_we_low"}, 32'(we_bad), 32'd0);
        check_eq({tag, "_busy_off"}, 32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_pos"}, 32'(start_seq_pos), 32'(e[31:16]));
            check_eq({tag, "_len"}, 32'(length), 32'(e[15:0]));
            last_pos = e[31:16];
            last_len = e[15:0];
        end
        @(negedge clock) start = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        start    = 1'b0;
        reset    = 1'b1;
        last_pos = '0;
        last_len = '0;
        fill(16'h0000);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check_eq("rst_address", 32'(address), 32'd0);
        check_eq("rst_we", 32'(write_enable), 32'd0);
        check_eq("rst_pos", 32'(start_seq_pos), 32'd0);
        check_eq("rst_len", 32'(length), 32'd0);
        check_eq("rst_finish", 32'(finish), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);

        // All zero: every element is its own run of 1.
        run_scan("zero", 16'd0, 16'd1);

        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 16'(i);
        run_scan("ramp_a", 16'd0, 16'd512);
        run_scan("ramp_b", 16'd0, 16'd512);

        fill(16'h0000);
        for (int i = 0; i < 5; i++) begin
            mem[10 + i]  = 16'(i);
            mem[100 + i] = 16'(i);
        end
        run_scan("tie", 16'd10, 16'd5);

        fill(16'h0000);
        for (int i = 0; i < 12; i++) mem[500 + i] = 16'(i);
        mem[0] = 16'hFFFF;
        run_scan("tail", 16'd500, 16'd12);

        fill(16'h0000);
        mem[20] = 16'd7;
        mem[21] = 16'd7;
        mem[22] = 16'd7;
        mem[29] = 16'hFFFF;  // isolates the 3..6 run from the zero before it
        for (int i = 0; i < 4; i++) mem[30 + i] = 16'(3 + i);
        run_scan("equal", 16'd30, 16'd4);

        // Abort mid-scan after a re-trigger attempt that must be ignored.
        @(negedge clock) start = 1'b1;
        @(posedge clock);
        for (int n = 1; n <= 200; n++) begin
            @(posedge clock);
            #1;
            if (n == 110) start = 1'b0;
            if (n == 120) start = 1'b1;
            if (n == 130) begin
                check_eq("retrig_addr", 32'(address), 32'd130);
                check_eq("retrig_busy", 32'(busy), 32'd1);
            end
        end
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        #1;
        check_eq("abort_address", 32'(address), 32'd0);
        check_eq("abort_finish", 32'(finish), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_pos", 32'(start_seq_pos), 32'd0);
        check_eq("abort_len", 32'(length), 32'd0);
        @(negedge clock) reset = 1'b0;
        last_pos = '0;
        last_len = '0;
        run_scan("rescan", 16'd30, 16'd4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
